// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit, 3-bit-opcode multi-cycle CPU: instruction
// field positions, opcodes, ALU function codes and sequencer states.
package cpu_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 29;
  localparam int RS_MSB  = 28;
  localparam int RS_LSB  = 24;
  localparam int RT_MSB  = 23;
  localparam int RT_LSB  = 19;
  localparam int RD_MSB  = 18;
  localparam int RD_LSB  = 14;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_HALT   = 3'b000;
  localparam opcode_t OP_ADD    = 3'b010;
  localparam opcode_t OP_SHIFTL = 3'b100;
  localparam opcode_t OP_ADDI   = 3'b110;
  localparam opcode_t OP_SUBI   = 3'b111;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_SHL = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
`ifdef SINGLE_STEP_EN
    , STEP_WAIT
`endif
  } state_t;

  function automatic logic op_is_illegal(input opcode_t op);
    return !(op inside {OP_HALT, OP_ADD, OP_SHIFTL, OP_ADDI, OP_SUBI});
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bus between the sequencer and its datapath: instruction memory, register
// file and ALU control. The controller takes the master modport.
interface multicycle_controller_if #(
   parameter int PC_W   = 5,
   parameter int REG_AW = 5,
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] instruction;
   logic [PC_W-1:0]   imem_addr;
   logic [REG_AW-1:0] rf_raddr1;
   logic [REG_AW-1:0] rf_raddr2;
   logic [REG_AW-1:0] rf_waddr;
   logic              rf_we;
   logic [1:0]        alu_op;
   logic              alu_src_imm;
   logic [DATA_W-1:0] imm;

   modport master (
      input  instruction,
      output imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we,
             alu_op, alu_src_imm, imm
   );

   modport slave (
      output instruction,
      input  imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we,
             alu_op, alu_src_imm, imm
   );
endinterface

// File: rtl/multicycle_controller_instr_decoder.sv
// Purely combinational instruction decoder: IR -> register fields, destination
// select, ALU controls, zero-extended immediate and halt/illegal flags.
module instr_decoder
   import cpu_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] ir,
   output logic [REG_AW-1:0] rs,
   output logic [REG_AW-1:0] rt,
   output logic [REG_AW-1:0] dest,
   output alu_op_t           alu_op,
   output logic              alu_src_imm,
   output logic [DATA_W-1:0] imm,
   output logic              is_halt,
   output logic              is_illegal
);
   opcode_t           op;
   logic [REG_AW-1:0] rd;

   assign op         = ir[OP_MSB:OP_LSB];
   assign rs         = ir[RS_MSB:RS_LSB];
   assign rt         = ir[RT_MSB:RT_LSB];
   assign rd         = ir[RD_MSB:RD_LSB];
   assign imm        = {{(DATA_W-16){1'b0}}, ir[IMM_MSB:IMM_LSB]};
   assign is_halt    = (op == OP_HALT);
   assign is_illegal = op_is_illegal(op);

   // R-type writes rd; I-type writes rt.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      alu_op      = ALU_ADD;
      alu_src_imm = 1'b0;
      dest        = rd;
      case (op)
         OP_SHIFTL: alu_op = ALU_SHL;
         OP_ADDI: begin
            alu_src_imm = 1'b1;
            dest        = rt;
         end
         OP_SUBI: begin
            alu_op      = ALU_SUB;
            alu_src_imm = 1'b1;
            dest        = rt;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_controller.sv
// Four-cycle-per-instruction sequencer: owns PC and IR, drives RF/ALU control.
// Define SINGLE_STEP_EN to add the step input and the STEP_WAIT state.
module multicycle_controller
   import cpu_pkg::*;
#(
   parameter int PC_W   = 5,
   parameter int REG_AW = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
`ifdef SINGLE_STEP_EN
   input  logic                   step,
`endif
   multicycle_controller_if.master bus,
   output logic                   busy,
   output logic                   halted,
   output logic                   illegal_op,
   output logic [CNT_W-1:0]       retire_cnt
);
   state_t            state;
   logic [PC_W-1:0]   pc;
   logic [DATA_W-1:0] ir;

   logic [REG_AW-1:0] dec_rs, dec_rt, dec_dest;
   alu_op_t           dec_alu_op;
   logic              dec_alu_src_imm;
   logic [DATA_W-1:0] dec_imm;
   logic              dec_is_halt, dec_is_illegal;

   instr_decoder #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_decoder (
      .ir          (ir),
      .rs          (dec_rs),
      .rt          (dec_rt),
      .dest        (dec_dest),
      .alu_op      (dec_alu_op),
      .alu_src_imm (dec_alu_src_imm),
      .imm         (dec_imm),
      .is_halt     (dec_is_halt),
      .is_illegal  (dec_is_illegal)
   );

   assign bus.imem_addr = pc;

   // NOTE: every register here uses <= so all updates see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         pc              <= '0;
         ir              <= '0;
         bus.rf_raddr1   <= '0;
         bus.rf_raddr2   <= '0;
         bus.rf_waddr    <= '0;
         bus.rf_we       <= 1'b0;
         bus.alu_op      <= ALU_ADD;
         bus.alu_src_imm <= 1'b0;
         bus.imm         <= '0;
         busy            <= 1'b0;
         halted          <= 1'b0;
         illegal_op      <= 1'b0;
         retire_cnt      <= '0;
      end else begin
         bus.rf_we  <= 1'b0;
         illegal_op <= 1'b0;
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  pc         <= '0;
                  retire_cnt <= '0;
                  busy       <= 1'b1;
                  halted     <= 1'b0;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               ir <= bus.instruction;
               // Flag decoded from the incoming word so the pulse lands in DECODE.
               illegal_op <= op_is_illegal(bus.instruction[OP_MSB:OP_LSB]);
               state      <= DECODE;
            end
            DECODE: begin
               if (dec_is_halt) begin
                  busy   <= 1'b0;
                  halted <= 1'b1;
                  state  <= HALT;
               end else if (dec_is_illegal) begin
                  pc    <= pc + PC_W'(1);
                  state <= FETCH;
               end else begin
                  bus.rf_raddr1   <= dec_rs;
                  bus.rf_raddr2   <= dec_rt;
                  bus.rf_waddr    <= dec_dest;
                  bus.alu_op      <= dec_alu_op;
                  bus.alu_src_imm <= dec_alu_src_imm;
                  bus.imm         <= dec_imm;
                  state           <= EXECUTE;
               end
            end
            EXECUTE: begin
               // r0 is hard zero: the write is suppressed, the instruction still retires.
               bus.rf_we <= (bus.rf_waddr != '0);
               state     <= WRITEBACK;
            end
            WRITEBACK: begin
               pc         <= pc + PC_W'(1);
               retire_cnt <= retire_cnt + CNT_W'(1);
`ifdef SINGLE_STEP_EN
               busy       <= 1'b0;
               state      <= STEP_WAIT;
`else
               state      <= FETCH;
`endif
            end
`ifdef SINGLE_STEP_EN
            STEP_WAIT: begin
               if (step) begin
                  busy  <= 1'b1;
                  state <= FETCH;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with behavioural imem, register file
// and ALU around it; expected values are hand-computed constants.
module tb_multicycle_controller;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        step;
   logic        busy, halted, illegal_op;
   logic [15:0] retire_cnt;
   logic        rf_clr;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] imem [32];
   logic [31:0] rf   [32];
   logic [31:0] alu_b, alu_y;

   int          we_cyc [$];
   logic [4:0]  we_addr[$];
   logic [1:0]  we_alu [$];
   logic [31:0] we_imm [$];
   int          ill_cyc[$];

   always #5 clk = ~clk;

   multicycle_controller_if #(.PC_W(5), .REG_AW(5), .DATA_W(32)) bus ();

   multicycle_controller #(.PC_W(5), .REG_AW(5), .DATA_W(32), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
`ifdef SINGLE_STEP_EN
      .step       (step),
`endif
      .bus        (bus.master),
      .busy       (busy),
      .halted     (halted),
      .illegal_op (illegal_op),
      .retire_cnt (retire_cnt)
   );

   assign bus.instruction = imem[bus.imem_addr];
   assign alu_b = bus.alu_src_imm ? bus.imm : rf[bus.rf_raddr2];

   always_comb begin
      alu_y = '0;
      case (bus.alu_op)
         2'b00:   alu_y = rf[bus.rf_raddr1] + alu_b;
         2'b01:   alu_y = rf[bus.rf_raddr1] - alu_b;
         2'b10:   alu_y = rf[bus.rf_raddr1] << alu_b[4:0];
         default: alu_y = '0;
      endcase
   end

   always @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (bus.rf_we && bus.rf_waddr != 5'd0) begin
         rf[bus.rf_waddr] <= alu_y;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [2:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 14'b0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [2:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, 3'b000, imm};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 32; i++) imem[i] = 32'h0;
   endtask

   // Reset the DUT and clear the register file; leaves us at a negedge, rst low.
   task automatic do_reset();
      rst    = 1'b1;
      rf_clr = 1'b1;
      start  = 1'b0;
      repeat (2) @(negedge clk);
      rf_clr = 1'b0;
      rst    = 1'b0;
      @(negedge clk);
   endtask

   // Pulse start; returns at the negedge of cycle 0 (first FETCH).
   task automatic start_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_until_halt(input int budget, input int poke, output int cyc);
      we_cyc.delete(); we_addr.delete(); we_alu.delete(); we_imm.delete(); ill_cyc.delete();
      cyc = -1;
      for (int c = 0; c < budget; c++) begin
         start = (c == poke);
         if (halted) begin
            cyc = c;
            break;
         end
         if (bus.rf_we) begin
            we_cyc.push_back(c);
            we_addr.push_back(bus.rf_waddr);
            we_alu.push_back(bus.alu_op);
            we_imm.push_back(bus.imm);
         end
         if (illegal_op) ill_cyc.push_back(c);
         @(negedge clk);
      end
      start = 1'b0;
      if (cyc < 0) check("halt_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int          cyc;
      logic [4:0]  exp_addr [6];
      int          we_seen;

      step   = 1'b1;
      rst    = 1'b1;
      rf_clr = 1'b1;
      start  = 1'b0;
      clear_imem();
      @(negedge clk);
      check("rst_busy",        busy,            0);
      check("rst_halted",      halted,          0);
      check("rst_illegal",     illegal_op,      0);
      check("rst_rf_we",       bus.rf_we,       0);
      check("rst_imem_addr",   bus.imem_addr,   0);
      check("rst_alu_op",      bus.alu_op,      0);
      check("rst_alu_src_imm", bus.alu_src_imm, 0);
      check("rst_imm",         bus.imm,         0);
      check("rst_retire",      retire_cnt,      0);

      // Six-instruction program followed by HALT.
      imem[0] = enc_i(3'b110, 5'd0,  5'd10, 16'd10);
      imem[1] = enc_i(3'b110, 5'd0,  5'd15, 16'd15);
      imem[2] = enc_r(3'b010, 5'd10, 5'd15, 5'd25);
      imem[3] = enc_i(3'b111, 5'd25, 5'd20, 16'd5);
      imem[4] = enc_i(3'b110, 5'd0,  5'd5,  16'd2);
      imem[5] = enc_r(3'b100, 5'd25, 5'd5,  5'd30);
      do_reset();
      start_run();
      run_until_halt(40, -1, cyc);
      check("prog_halt_cycle", cyc, 26);
      check("prog_we_count", we_cyc.size(), 6);
      exp_addr = '{5'd10, 5'd15, 5'd25, 5'd20, 5'd5, 5'd30};
      for (int k = 0; k < we_cyc.size() && k < 6; k++) begin
         check($sformatf("prog_we_cycle%0d", k), we_cyc[k], 4 * k + 3);
         check($sformatf("prog_waddr%0d", k), we_addr[k], exp_addr[k]);
      end
      if (we_cyc.size() >= 4) begin
         check("add_alu_op",  we_alu[2], 2'b00);
         check("subi_alu_op", we_alu[3], 2'b01);
         check("subi_imm",    we_imm[3], 5);
      end
      check("prog_illegal", ill_cyc.size(), 0);
      check("rf_r10", rf[10], 10);
      check("rf_r15", rf[15], 15);
      check("rf_r25", rf[25], 25);
      check("rf_r20", rf[20], 20);
      check("rf_r5",  rf[5],  2);
      check("rf_r30", rf[30], 100);
      check("prog_retire", retire_cnt, 6);
      check("prog_busy_halted", busy, 0);

      // Write to r0 retires but never pulses rf_we.
      clear_imem();
      imem[0] = enc_i(3'b110, 5'd1, 5'd0, 16'd7);
      do_reset();
      start_run();
      run_until_halt(20, -1, cyc);
      check("r0_we_count", we_cyc.size(), 0);
      check("r0_retire",   retire_cnt,    1);
      check("r0_halt_cyc", cyc,           6);

      // Illegal opcode at PC 0 is skipped as a NOP.
      clear_imem();
      imem[0] = {3'b001, 29'h0};
      do_reset();
      start_run();
      run_until_halt(20, -1, cyc);
      check("ill_pulses", ill_cyc.size(), 1);
      if (ill_cyc.size() > 0) check("ill_cycle", ill_cyc[0], 1);
      check("ill_halt_cyc", cyc,           4);
      check("ill_pc",       bus.imem_addr, 1);
      check("ill_retire",   retire_cnt,    0);
      check("ill_we_count", we_cyc.size(), 0);

      // Reset asserted during EXECUTE of an ADD.
      clear_imem();
      imem[0] = enc_r(3'b010, 5'd1, 5'd2, 5'd3);
      do_reset();
      start_run();
      repeat (2) @(negedge clk);
      check("abort_exec_raddr1", bus.rf_raddr1, 1);
      rst = 1'b1;
      #1;
      check("abort_busy",   busy,          0);
      check("abort_rf_we",  bus.rf_we,     0);
      check("abort_raddr1", bus.rf_raddr1, 0);
      check("abort_waddr",  bus.rf_waddr,  0);
      check("abort_pc",     bus.imem_addr, 0);
      we_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.rf_we) we_seen++;
      end
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.rf_we) we_seen++;
      end
      check("abort_we_seen", we_seen, 0);
      check("abort_idle",    busy,    0);
      check("abort_rf_r3",   rf[3],   0);

      // PC wrap-around with ADDI r1,r1,1 in every word.
      for (int i = 0; i < 32; i++) imem[i] = enc_i(3'b110, 5'd1, 5'd1, 16'd1);
      do_reset();
      start_run();
      for (int c = 0; c <= 136; c++) begin
         if (c == 124) check("wrap_pc31", bus.imem_addr, 31);
         if (c == 128) begin
            check("wrap_pc0",  bus.imem_addr, 0);
            check("wrap_r1_32", rf[1], 32);
         end
         if (c == 136) begin
            check("wrap_pc2",     bus.imem_addr, 2);
            check("wrap_r1_34",   rf[1],         34);
            check("wrap_retire",  retire_cnt,    34);
         end
         @(negedge clk);
      end

      // Restart from HALT; a start pulse while busy is ignored.
      clear_imem();
      imem[0] = enc_i(3'b110, 5'd1, 5'd1, 16'd1);
      imem[1] = enc_i(3'b110, 5'd1, 5'd1, 16'd1);
      do_reset();
      start_run();
      run_until_halt(20, -1, cyc);
      check("rs1_halt_cyc", cyc,           10);
      check("rs1_retire",   retire_cnt,    2);
      check("rs1_pc",       bus.imem_addr, 2);
      start_run();
      check("rs2_halted", halted,        0);
      check("rs2_busy",   busy,          1);
      check("rs2_pc",     bus.imem_addr, 0);
      check("rs2_retire", retire_cnt,    0);
      run_until_halt(20, 5, cyc);
      check("rs2_halt_cyc", cyc,        10);
      check("rs2_retire2",  retire_cnt, 2);
      check("rs2_r1",       rf[1],      4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the 32-bit, 3-bit-opcode CPU.
- Owns the PC and drives the instruction memory address. Latches the returned instruction into an IR and decodes it.
- Sequences register-file reads, ALU operation select and register write-back over 4 cycles per instruction.
- Sits between instruction memory, register file and ALU; the top level wires these three around it.

Parameters:
PC_W, 5, PC / instruction-memory address width
REG_AW, 5, register-file address width
DATA_W, 32, instruction and immediate-extended width
CNT_W, 16, retired-instruction counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin execution from PC 0 (sampled in IDLE/HALT)
instruction  input  DATA_W  combinational instruction-memory read data
imem_addr  output  PC_W  instruction-memory address (= PC)
rf_raddr1  output  REG_AW  register-file read port 1 (rs)
rf_raddr2  output  REG_AW  register-file read port 2 (rt)
rf_waddr  output  REG_AW  register-file write address
rf_we  output  1  register-file write enable, one-cycle pulse
alu_op  output  2  ALU function select
alu_src_imm  output  1  1 = ALU operand B is imm, 0 = rf read port 2
imm  output  DATA_W  zero-extended IR[15:0]
busy  output  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
halted  output  1  high in HALT
illegal_op  output  1  one-cycle pulse on unsupported opcode
retire_cnt  output  CNT_W  instructions retired since start

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, PC=0, IR=0, rf_we=0, alu_op=ADD, alu_src_imm=0, imm=0, busy=0, halted=0, illegal_op=0, retire_cnt=0.
- Reset asserted mid-instruction aborts it at once; no rf_we is issued.
- Instruction encoding: op=IR[31:29], rs=IR[28:24], rt=IR[23:19].
  - R-type: rd=IR[18:14].
  - I-type: destination=rt, imm=IR[15:0].
- Opcodes:
  - 000 HALT
  - 010 ADD (rd=rs+rt)
  - 100 SHIFTL (rd=rs<<rt)
  - 110 ADDI (rt=rs+imm)
  - 111 SUBI (rt=rs-imm)
  - 001, 011, 101 illegal.
- alu_op encoding: 00 ADD, 01 SUB, 10 SHL, 11 reserved.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
  - IDLE: wait; start=1 -> PC=0, retire_cnt=0, go FETCH.
  - FETCH: imem_addr=PC; IR<=instruction at cycle end -> DECODE.
  - DECODE: rf_raddr1=rs, rf_raddr2=rt from IR; imm, alu_op, alu_src_imm registered from IR.
    - op=000 -> HALT.
    - Illegal op -> illegal_op pulse, PC<=PC+1, -> FETCH (NOP, not retired).
    - Otherwise -> EXECUTE.
  - EXECUTE: read addresses, alu_op, alu_src_imm and imm held stable for the ALU -> WRITEBACK.
  - WRITEBACK: rf_waddr = rd (R-type) or rt (I-type).
    - rf_we=1 for exactly this cycle, except destination r0: rf_we stays 0 (r0 is hard zero).
    - PC<=PC+1; retire_cnt<=retire_cnt+1; -> FETCH.
  - HALT: halted=1; start=1 -> PC=0, retire_cnt=0, FETCH.
- Latency: 4 cycles per retired instruction; HALT reached 2 cycles after its fetch.
- PC wrap-around: PC=31 increments to 0 with no flag. retire_cnt wraps modulo 2^CNT_W.
- start is ignored while busy=1.
- Control outputs stay at their last values outside EXECUTE/WRITEBACK; only rf_we is qualified.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- With the macro defined:
  - Extra input step (1 bit) and state STEP_WAIT.
  - WRITEBACK goes to STEP_WAIT instead of FETCH.
  - STEP_WAIT holds until step=1, then goes to FETCH.
  - busy=0 in STEP_WAIT.
- Without the macro: no step port, WRITEBACK -> FETCH directly.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_HALT, OP_ADD, OP_SHIFTL, OP_ADDI, OP_SUBI)
  - alu_op codes (ALU_ADD, ALU_SUB, ALU_SHL)
  - FSM state encoding
  - field bit positions
- One natural sub-module: instr_decoder. It is purely combinational: IR -> rs/rt/rd, dest select, alu_op, alu_src_imm, imm, is_halt, is_illegal. The FSM stays in multicycle_controller.

Test Plan:
- Reset then start; run the 6-instruction program with behavioural imem, RF and ALU:
  - ADDI r10,r0,10; ADDI r15,r0,15; ADD r25,r10,r15; SUBI r20,r25,5; ADDI r5,r0,2; SHIFTL r30,r25,r5
  - Word 6 = 0 (HALT).
  - Required: RF r10=10, r15=15, r25=25, r20=20, r5=2, r30=100.
  - retire_cnt=6; halted rises 26 cycles after start accepted.
- Per-instruction timing: rf_we high for exactly 1 cycle, 4 cycles apart. rf_waddr=25 with alu_op=00 for ADD; rf_waddr=20 with alu_op=01 and imm=5 for SUBI.
- Write to r0: ADDI r0,r1,7 -> rf_we never asserts, retire_cnt still increments.
- Illegal opcode 001 at PC 0 -> illegal_op pulses once in DECODE, PC advances to 1, retire_cnt unchanged.
- Assert rst during EXECUTE of ADD -> no rf_we; all outputs return to reset values immediately, state IDLE.
- Wrap and restart:
  - Fill all 32 words with ADDI r1,r1,1: PC goes 31->0 and r1 keeps counting.
  - Separately, start in HALT restarts from PC 0 with retire_cnt=0.
